regfile_bypass_sb: RTL and testbench

- Parametrised successor to the CPU's 32x32 register file, used in the pipelined datapath.
- Provides N_READ combinational read ports and one synchronous write port.
- Includes write-to-read bypass, a hardwired zero register, and a per-register busy scoreboard for hazard detection.
- Decode reads operands and hazard status here; writeback drives the write port.

---
 rtl/regfile_bypass_sb.sv | 84 ++++++++
 tb/tb_regfile_bypass_sb.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_bypass_sb.sv
// Parametrised register file: N_READ combinational read ports, one write port,
// write-to-read bypass, optional hardwired zero register and a busy scoreboard.
module regfile_bypass_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned N_READ   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [N_READ*ADDR_W-1:0]   rd_addr,
    output logic [N_READ*DATA_W-1:0]   rd_data,
    output logic [N_READ-1:0]          rd_busy,
    input  logic                       busy_set,
    input  logic [ADDR_W-1:0]          busy_addr,
    output logic [(2**ADDR_W)-1:0]     busy_vec
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic              wr_ok;
    logic              set_ok;
    logic [ADDR_W-1:0] ra;

    assign wr_ok  = wr_en    && !((ZERO_REG != 0) && (wr_addr   == '0));
    assign set_ok = busy_set && !((ZERO_REG != 0) && (busy_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Set is applied after clear so a producer issued as the old one retires keeps the bit.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (set_ok) begin
            busy_d[busy_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    // Reset forces outputs low so a write strobe held during reset cannot leak through the bypass.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int unsigned k = 0; k < N_READ; k++) begin
            ra = rd_addr[k*ADDR_W +: ADDR_W];
            if (!rst_n || ((ZERO_REG != 0) && (ra == '0))) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
                rd_busy[k]                  = 1'b0;
            end else if (wr_ok && (wr_addr == ra)) begin
                rd_data[k*DATA_W +: DATA_W] = wr_data;
                rd_busy[k]                  = 1'b0;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = mem_q[ra];
                rd_busy[k]                  = busy_q[ra];
            end
        end
    end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed bench for regfile_bypass_sb: default configuration plus a
// 4-port, 64-bit instance for the reset/bypass parameter sweep.
module tb_regfile_bypass_sb;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: DATA_W=32, ADDR_W=5, N_READ=2, ZERO_REG=1
    logic        a_rst_n, a_wr_en, a_busy_set;
    logic [4:0]  a_wr_addr, a_busy_addr;
    logic [31:0] a_wr_data;
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [31:0] a_busy_vec;

    regfile_bypass_sb #(.DATA_W(32), .ADDR_W(5), .N_READ(2), .ZERO_REG(1)) u_a (
        .clk(clk), .rst_n(a_rst_n), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
        .wr_data(a_wr_data), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .rd_busy(a_rd_busy), .busy_set(a_busy_set), .busy_addr(a_busy_addr),
        .busy_vec(a_busy_vec)
    );

    // Instance B: DATA_W=64, N_READ=4
    logic         b_rst_n, b_wr_en, b_busy_set;
    logic [4:0]   b_wr_addr, b_busy_addr;
    logic [63:0]  b_wr_data;
    logic [19:0]  b_rd_addr;
    logic [255:0] b_rd_data;
    logic [3:0]   b_rd_busy;
    logic [31:0]  b_busy_vec;

    regfile_bypass_sb #(.DATA_W(64), .ADDR_W(5), .N_READ(4), .ZERO_REG(1)) u_b (
        .clk(clk), .rst_n(b_rst_n), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .busy_set(b_busy_set), .busy_addr(b_busy_addr),
        .busy_vec(b_busy_vec)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst_n = 1'b0; a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
        a_rd_addr = '0; a_busy_set = 1'b0; a_busy_addr = '0;
        b_rst_n = 1'b0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        b_rd_addr = '0; b_busy_set = 1'b0; b_busy_addr = '0;
        #1;

        // Reset: all addresses read 0 on both ports, scoreboard clear
        chk("rst_busy_vec", 256'(a_busy_vec), 256'(32'h0));
        for (int a = 0; a < 32; a++) begin
            a_rd_addr = {5'(a), 5'(31 - a)};
            #1;
            chk("rst_rd_data", 256'(a_rd_data), 256'(64'h0));
            chk("rst_rd_busy", 256'(a_rd_busy), 256'(2'b00));
        end

        // Writes and busy_set during reset are ignored, no bypass either
        a_wr_en = 1'b1; a_wr_addr = 5'd4; a_wr_data = 32'hCAFE0004;
        a_busy_set = 1'b1; a_busy_addr = 5'd4; a_rd_addr = {5'd4, 5'd4};
        #1;
        chk("rst_no_bypass", 256'(a_rd_data), 256'(64'h0));
        tick();
        a_wr_en = 1'b0; a_busy_set = 1'b0;
        #1;
        chk("rst_no_write", 256'(a_rd_data), 256'(64'h0));
        chk("rst_no_busy", 256'(a_busy_vec), 256'(32'h0));
        a_rst_n = 1'b1;
        tick();

        // Same-cycle bypass, then stored value
        a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF; a_rd_addr = {5'd0, 5'd5};
        #1;
        chk("bypass_5", 256'(a_rd_data[31:0]), 256'(32'hDEADBEEF));
        tick();
        a_wr_en = 1'b0;
        #1;
        chk("stored_5", 256'(a_rd_data[31:0]), 256'(32'hDEADBEEF));
        a_rd_addr = {5'd5, 5'd5};
        #1;
        chk("dual_port_5", 256'(a_rd_data), 256'({32'hDEADBEEF, 32'hDEADBEEF}));

        // Zero register: write dropped, bypass suppressed, busy never set
        a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'h1234; a_rd_addr = {5'd0, 5'd0};
        #1;
        chk("zero_no_bypass", 256'(a_rd_data), 256'(64'h0));
        tick();
        a_wr_en = 1'b0; a_busy_set = 1'b1; a_busy_addr = 5'd0;
        #1;
        chk("zero_read", 256'(a_rd_data), 256'(64'h0));
        tick();
        a_busy_set = 1'b0;
        #1;
        chk("zero_busy_vec", 256'(a_busy_vec), 256'(32'h0));
        chk("zero_rd_busy", 256'(a_rd_busy), 256'(2'b00));

        // Scoreboard set, bypassed retire clears stall, then clears bit
        a_busy_set = 1'b1; a_busy_addr = 5'd7;
        tick();
        a_busy_set = 1'b0; a_rd_addr = {5'd7, 5'd5};
        #1;
        chk("busy7_vec", 256'(a_busy_vec), 256'(32'h0000_0080));
        chk("busy7_rd_busy", 256'(a_rd_busy), 256'(2'b10));
        a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'hA5;
        #1;
        chk("retire7_rd_busy", 256'(a_rd_busy), 256'(2'b00));
        chk("retire7_bypass", 256'(a_rd_data[63:32]), 256'(32'hA5));
        tick();
        a_wr_en = 1'b0;
        #1;
        chk("retire7_vec", 256'(a_busy_vec), 256'(32'h0));
        chk("retire7_data", 256'(a_rd_data[63:32]), 256'(32'hA5));

        // Same-cycle set and clear on reg 3: set wins, data written
        a_busy_set = 1'b1; a_busy_addr = 5'd3;
        a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'h55;
        tick();
        a_wr_en = 1'b0; a_rd_addr = {5'd5, 5'd3};
        #1;
        chk("setwins_data", 256'(a_rd_data[31:0]), 256'(32'h55));
        chk("setwins_vec", 256'(a_busy_vec), 256'(32'h0000_0008));
        chk("setwins_rd_busy", 256'(a_rd_busy), 256'(2'b01));
        // Set again while busy, still set; a single write clears it
        tick();
        a_busy_set = 1'b0;
        #1;
        chk("reset_busy3_vec", 256'(a_busy_vec), 256'(32'h0000_0008));
        a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'h66;
        tick();
        a_wr_en = 1'b0;
        #1;
        chk("one_write_clears", 256'(a_busy_vec), 256'(32'h0));
        chk("reg3_new", 256'(a_rd_data[31:0]), 256'(32'h66));

        // Asynchronous reset mid-operation; held write not applied on next edge
        a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'hFF;
        tick();
        a_wr_en = 1'b0; a_busy_set = 1'b1; a_busy_addr = 5'd9;
        tick();
        a_busy_set = 1'b0; a_rd_addr = {5'd5, 5'd9};
        #1;
        chk("pre_rst_data9", 256'(a_rd_data[31:0]), 256'(32'hFF));
        chk("pre_rst_busy9", 256'(a_rd_busy), 256'(2'b01));
        #2;
        a_rst_n = 1'b0;
        #1;
        chk("async_rst_data", 256'(a_rd_data), 256'(64'h0));
        chk("async_rst_vec", 256'(a_busy_vec), 256'(32'h0));
        a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h77;
        tick();
        a_wr_en = 1'b0;
        a_rst_n = 1'b1;
        tick();
        chk("no_partial_write", 256'(a_rd_data), 256'(64'h0));

        // Instance B: 4 ports, 64-bit data
        #1;
        b_rd_addr = {5'd9, 5'd9, 5'd9, 5'd9};
        #1;
        chk("b_rst_data", 256'(b_rd_data), 256'(0));
        b_rst_n = 1'b1;
        tick();
        b_wr_en = 1'b1; b_wr_addr = 5'd9; b_wr_data = 64'h0123_4567_89AB_CDEF;
        b_busy_set = 1'b1; b_busy_addr = 5'd9;
        b_rd_addr = {5'd9, 5'd0, 5'd9, 5'd2};
        #1;
        chk("b_bypass_p1", 256'(b_rd_data[127:64]), 256'(64'h0123_4567_89AB_CDEF));
        chk("b_bypass_p3", 256'(b_rd_data[255:192]), 256'(64'h0123_4567_89AB_CDEF));
        chk("b_zero_p2", 256'(b_rd_data[191:128]), 256'(64'h0));
        tick();
        b_wr_en = 1'b0; b_busy_set = 1'b0;
        b_rd_addr = {5'd9, 5'd9, 5'd9, 5'd9};
        #1;
        chk("b_data_all", 256'(b_rd_data), {4{64'h0123_4567_89AB_CDEF}});
        chk("b_busy_all", 256'(b_rd_busy), 256'(4'b1111));
        chk("b_vec", 256'(b_busy_vec), 256'(32'h0000_0200));
        #2;
        b_rst_n = 1'b0;
        #1;
        chk("b_async_data", 256'(b_rd_data), 256'(0));
        chk("b_async_vec", 256'(b_busy_vec), 256'(32'h0));
        chk("b_async_busy", 256'(b_rd_busy), 256'(4'b0000));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
